// File: rtl/if_queue.sv
// Fetch-side instruction queue: buffers {PC, Instr} beats from the PC register
// and instruction memory ahead of IF/ID, back-pressures fetch when full and
// squashes wrong-path entries on a branch/jump redirect.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal operation; fetch beats enqueue when there is room
//   FLUSH   | Redirect asserted this cycle; queue cleared, beat dropped
//   SQUASH  | sq_cnt != 0; in-flight wrong-path beats are discarded
module if_queue #(
    parameter int DEPTH         = 4,
    parameter int PTR_W         = 2,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic [31:0]      Instr,
    input  logic             Fetch_Valid,
    input  logic             Redirect,
    output logic             Stall_Fetch,
    output logic             ID_Valid,
    input  logic             ID_Ready,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_Instr,
    output logic [PTR_W:0]   Occupancy
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_SQUASH
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]     SQ_LOAD  = 2'(SQUASH_CYCLES);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic [1:0]       sq_cnt;
    logic [1:0]       sq_cnt_nxt;
    state_t           state;
    logic             full;
    logic             enq;
    logic             deq;

    // Output decode straight from the count and head slot; no bypass path.
    assign full        = (count == FULL_CNT);
    assign Stall_Fetch = full;
    assign ID_Valid    = (count != '0) && !Redirect;
    assign ID_PC       = mem[rd_ptr][63:32];
    assign ID_Instr    = mem[rd_ptr][31:0];
    assign Occupancy   = count;

    // State decode, handshakes and next squash/count values.
    // FLUSH is a combinational view of Redirect, so the squash counter is
    // the only stored part of the control state.
    always_comb begin
        state      = ST_RUN;
        sq_cnt_nxt = '0;
        count_nxt  = count;
        if (Redirect) begin
            state = ST_FLUSH;
        end else if (sq_cnt != '0) begin
            state = ST_SQUASH;
        end

        enq = Fetch_Valid && !full && (state == ST_RUN);
        deq = ID_Valid && ID_Ready;

        case (state)
            ST_FLUSH:  sq_cnt_nxt = SQ_LOAD;
            ST_SQUASH: sq_cnt_nxt = sq_cnt - 2'd1;
            default:   sq_cnt_nxt = '0;
        endcase

        case ({enq, deq})
            2'b10:   count_nxt = count + (PTR_W + 1)'(1);
            2'b01:   count_nxt = count - (PTR_W + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer, occupancy and squash-counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sq_cnt <= '0;
        end else begin
            sq_cnt <= sq_cnt_nxt;
            if (state == ST_FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
                if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_nxt;
            end
        end
    end

    // Entry storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge Clock) begin
        if (!Reset && enq) begin
            mem[wr_ptr] <= {PC, Instr};
        end
    end

    // Occupancy must stay within 0..DEPTH and never dequeue from empty.
    always @(posedge Clock) begin
        if (!Reset) begin
            assert (count <= FULL_CNT)
                else $error("if_queue occupancy overflow: %0d", count);
            assert (!(deq && count == '0))
                else $error("if_queue dequeue while empty");
        end
    end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (DEPTH=4, SQUASH_CYCLES=1).
module tb_if_queue;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        Fetch_Valid;
    logic        Redirect;
    logic        Stall_Fetch;
    logic        ID_Valid;
    logic        ID_Ready;
    logic [31:0] ID_PC;
    logic [31:0] ID_Instr;
    logic [2:0]  Occupancy;

    int total = 0;
    int bad   = 0;

    if_queue #(.DEPTH(4), .PTR_W(2), .SQUASH_CYCLES(1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PC          (PC),
        .Instr       (Instr),
        .Fetch_Valid (Fetch_Valid),
        .Redirect    (Redirect),
        .Stall_Fetch (Stall_Fetch),
        .ID_Valid    (ID_Valid),
        .ID_Ready    (ID_Ready),
        .ID_PC       (ID_PC),
        .ID_Instr    (ID_Instr),
        .Occupancy   (Occupancy)
    );

    initial forever #5 Clock = ~Clock;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic beat(input logic fv, input logic [31:0] pc);
        Fetch_Valid = fv;
        PC          = pc;
        Instr       = instr_of(pc);
    endtask

    initial begin
        Reset = 1'b1; ID_Ready = 1'b0; Redirect = 1'b0;
        beat(1'b0, 32'h0);
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("rst_occ",   32'(Occupancy),   32'd0);
        chk("rst_valid", 32'(ID_Valid),    32'd0);
        chk("rst_stall", 32'(Stall_Fetch), 32'd0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 32'h3000 + 32'(4 * i));
            tick();
        end
        #1;
        chk("fill_occ",   32'(Occupancy),   32'd4);
        chk("fill_stall", 32'(Stall_Fetch), 32'd1);
        chk("fill_valid", 32'(ID_Valid),    32'd1);
        chk("fill_head",  ID_PC,            32'h3000);

        // Fifth beat while full is refused.
        beat(1'b1, 32'h3010);
        tick();
        #1;
        chk("full_occ",  32'(Occupancy), 32'd4);
        chk("full_head", ID_PC,          32'h3000);

        // One dequeue releases the stall, then the held beat is taken.
        ID_Ready = 1'b1;
        #1;
        chk("deq_pc",    ID_PC,    32'h3000);
        chk("deq_instr", ID_Instr, instr_of(32'h3000));
        tick();
        ID_Ready = 1'b0;
        #1;
        chk("deq_occ",   32'(Occupancy),   32'd3);
        chk("deq_stall", 32'(Stall_Fetch), 32'd0);
        tick();
        #1;
        chk("refill_occ",   32'(Occupancy),   32'd4);
        chk("refill_stall", 32'(Stall_Fetch), 32'd1);

        // Drain to one entry, checking order.
        beat(1'b0, 32'h0);
        ID_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_pc", ID_PC, 32'h3004 + 32'(4 * i));
            tick();
        end
        #1;
        chk("drain_occ", 32'(Occupancy), 32'd1);

        // Stream: one in, one out per cycle across several wraps.
        for (int k = 0; k < 10; k++) begin
            beat(1'b1, 32'h3014 + 32'(4 * k));
            #1;
            chk("stream_pc",    ID_PC,    32'h3010 + 32'(4 * k));
            chk("stream_instr", ID_Instr, instr_of(32'h3010 + 32'(4 * k)));
            tick();
            #1;
            chk("stream_occ", 32'(Occupancy), 32'd1);
        end

        // Build 3 entries, then redirect.
        ID_Ready = 1'b0;
        beat(1'b1, 32'h303C); tick();
        beat(1'b1, 32'h3040); tick();
        #1;
        chk("pre_redir_occ", 32'(Occupancy), 32'd3);
        Redirect = 1'b1;
        ID_Ready = 1'b1;
        beat(1'b1, 32'h3044);
        #1;
        chk("redir_valid", 32'(ID_Valid), 32'd0);
        tick();
        Redirect = 1'b0;
        beat(1'b1, 32'h3048);
        #1;
        chk("flush_occ",   32'(Occupancy), 32'd0);
        chk("flush_valid", 32'(ID_Valid),  32'd0);
        tick();
        ID_Ready = 1'b0;
        beat(1'b1, 32'h4000);
        #1;
        chk("squash_drop_occ", 32'(Occupancy), 32'd0);
        tick();
        beat(1'b0, 32'h0);
        #1;
        chk("target_occ",   32'(Occupancy), 32'd1);
        chk("target_valid", 32'(ID_Valid),  32'd1);
        chk("target_pc",    ID_PC,          32'h4000);
        chk("target_instr", ID_Instr,       instr_of(32'h4000));

        // Redirect while full drops the stall.
        beat(1'b1, 32'h4004); tick();
        beat(1'b1, 32'h4008); tick();
        beat(1'b1, 32'h400C); tick();
        #1;
        chk("full2_stall", 32'(Stall_Fetch), 32'd1);
        Redirect = 1'b1;
        beat(1'b1, 32'h4010);
        tick();
        Redirect = 1'b0;
        beat(1'b0, 32'h0);
        #1;
        chk("full_redir_stall", 32'(Stall_Fetch), 32'd0);
        chk("full_redir_occ",   32'(Occupancy),   32'd0);
        chk("full_redir_valid", 32'(ID_Valid),    32'd0);
        tick();
        beat(1'b1, 32'h5000);
        tick();
        beat(1'b0, 32'h0);
        #1;
        chk("after_full_occ", 32'(Occupancy), 32'd1);
        chk("after_full_pc",  ID_PC,          32'h5000);

        // Back-to-back redirects reload the squash window.
        Redirect = 1'b1;
        tick();
        beat(1'b1, 32'h6000);
        tick();
        Redirect = 1'b0;
        beat(1'b1, 32'h6004);
        tick();
        #1;
        chk("resquash_occ", 32'(Occupancy), 32'd0);
        beat(1'b1, 32'h6008);
        tick();
        beat(1'b1, 32'h600C);
        tick();
        beat(1'b0, 32'h0);
        #1;
        chk("resquash_occ2", 32'(Occupancy), 32'd2);
        chk("resquash_pc",   ID_PC,          32'h6008);

        // Reset with entries pending and decode ready.
        Reset    = 1'b1;
        ID_Ready = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ID_Valid),    32'd0);
        chk("mid_rst_occ",   32'(Occupancy),   32'd0);
        chk("mid_rst_stall", 32'(Stall_Fetch), 32'd0);
        tick();
        #1;
        chk("mid_rst_occ2", 32'(Occupancy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
